// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

   // Widest digit bank the all-ones anode constant can cover.
   localparam int MAX_DIGITS = 32;

   // Active-low anodes: all ones means every digit is dark.
   localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

   // Default geometry and timing.
   localparam int DEF_NUM_DIGITS  = 4;
   localparam int DEF_REFRESH_DIV = 50000;
   localparam int DEF_GUARD       = 2;

   // Scan state: OFF keeps the bank dark, SCAN steps through the digits.
   typedef enum logic {
      OFF  = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Host/display bundle of the scan controller: value load handshake,
// display enable, and the decoder/anode drive toward the digit bank.
interface seven_seg_scan_ctrl_if
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS
);

   logic [4*NUM_DIGITS-1:0] value;
   logic                    load;
   logic                    display_on;
   logic                    upd_ack;
   logic [3:0]              digit_nib;
   logic                    dec_enable;
   logic [NUM_DIGITS-1:0]   anode;

   // Host side: supplies the value and controls, observes the display drive.
   modport master (
      output value, load, display_on,
      input  upd_ack, digit_nib, dec_enable, anode
   );

   // Controller side.
   modport slave (
      input  value, load, display_on,
      output upd_ack, digit_nib, dec_enable, anode
   );

endinterface

// File: rtl/seven_seg_prescaler.sv
// Slot-timing counter: counts 0..DIV-1 while enabled, synchronous clear,
// tick marks the last cycle of a slot.
module seven_seg_prescaler
   import seven_seg_pkg::*;
#(
   parameter int  DIV = DEF_REFRESH_DIV,
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          tick
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_reg;

   // Count up while enabled, wrapping at DIV-1; clear has priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         if (count_reg == LAST) begin
            count_reg <= '0;
         end else begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign count = count_reg;
   assign tick  = en && (count_reg == LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// A staged value moves into the shadow register only at a frame boundary
// (or while dark), so a displayed frame never mixes old and new digits.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
   parameter int REFRESH_DIV   = DEF_REFRESH_DIV,
   parameter int GUARD         = DEF_GUARD,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   seven_seg_scan_ctrl_if.slave bus
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int VW = 4 * NUM_DIGITS;

   localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];
   localparam logic [IW-1:0]         LAST_IDX      = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]         GUARD_CNT     = CW'(GUARD);

   scan_state_t state_reg, state_next;

   logic [IW-1:0] idx_reg;
   logic [CW-1:0] count_w;
   logic          tick_w;
   logic          scanning_w;
   logic          frame_wrap_w;
   logic          xfer_w;

   logic [VW-1:0] staging_reg;
   logic [VW-1:0] shadow_reg;
   logic          pending_reg;
   logic          upd_ack_reg;

   logic [3:0]            nib_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] blank_vec;

   logic [NUM_DIGITS-1:0] anode_next, anode_reg;
   logic [3:0]            nib_next, nib_reg;
   logic                  en_next, en_reg;

   // The scan only advances while in SCAN with the display still requested;
   // dropping display_on abandons the slot and clears the counters.
   assign scanning_w   = (state_reg == SCAN) && bus.display_on;
   assign frame_wrap_w = tick_w && (idx_reg == LAST_IDX);
   assign xfer_w       = pending_reg &&
                         ((state_reg == OFF) || ((state_reg == SCAN) && frame_wrap_w));

   seven_seg_prescaler #(
      .DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (scanning_w),
      .clr   (!scanning_w),
      .count (count_w),
      .tick  (tick_w)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= OFF;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: follow display_on.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         OFF:     if (bus.display_on)  state_next = SCAN;
         SCAN:    if (!bus.display_on) state_next = OFF;
         default: state_next = OFF;
      endcase
   end

   // Digit index: advances on each slot tick, restarts at 0 whenever idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg <= '0;
      end else if (!scanning_w) begin
         idx_reg <= '0;
      end else if (tick_w) begin
         idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      end
   end

   // Load handshake: stage the value, hand it to the shadow at a safe point.
   // A load in the transfer cycle bypasses staging so the newest value wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         staging_reg <= '0;
         shadow_reg  <= '0;
         pending_reg <= 1'b0;
         upd_ack_reg <= 1'b0;
      end else begin
         if (bus.load) begin
            staging_reg <= bus.value;
         end
         if (xfer_w) begin
            shadow_reg  <= bus.load ? bus.value : staging_reg;
            pending_reg <= 1'b0;
         end else if (bus.load) begin
            pending_reg <= 1'b1;
         end
         upd_ack_reg <= xfer_w;
      end
   end

   // Per-digit nibble taps and leading-zero blanking flags.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib_arr[gi] = shadow_reg[4*gi +: 4];
         if (gi == 0 || !BLANK_LEADING) begin : g_keep
            assign blank_vec[gi] = 1'b0;
         end else begin : g_blank
            assign blank_vec[gi] = (shadow_reg[VW-1:4*gi] == '0);
         end
      end
   endgenerate

   // Slot decode: anodes dark during the guard window, then select idx.
   always_comb begin
      anode_next = ANODE_ALL_OFF;
      nib_next   = 4'h0;
      en_next    = 1'b0;
      if (state_reg == SCAN) begin
         nib_next = nib_arr[idx_reg];
         en_next  = !blank_vec[idx_reg];
         if (count_w >= GUARD_CNT) begin
            anode_next[idx_reg] = 1'b0;
         end
      end
   end

   // Registered outputs, one clock behind the internal scan position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode_reg <= ANODE_ALL_OFF;
         nib_reg   <= 4'h0;
         en_reg    <= 1'b0;
      end else begin
         anode_reg <= anode_next;
         nib_reg   <= nib_next;
         en_reg    <= en_next;
      end
   end

   assign bus.anode      = anode_reg;
   assign bus.digit_nib  = nib_reg;
   assign bus.dec_enable = en_reg;
   assign bus.upd_ack    = upd_ack_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Table-driven bench for seven_seg_scan_ctrl (4 digits, 4-cycle slots, 1-cycle guard).
// Each table row is one clock: inputs applied, then outputs sampled after the edge.
module tb_seven_seg_scan_ctrl;

   localparam int ND = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan_ctrl #(
      .NUM_DIGITS    (ND),
      .REFRESH_DIV   (4),
      .GUARD         (1),
      .BLANK_LEADING (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        don;
      logic        ld;
      logic [15:0] val;
      logic [3:0]  an;
      logic [3:0]  nib;
      logic        en;
      logic        ack;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_row(input logic don, input logic ld, input logic [15:0] val,
                          input logic [3:0] an, input logic [3:0] nib,
                          input logic en, input logic ack);
      vec_t v;
      v.don = don; v.ld = ld; v.val = val;
      v.an = an; v.nib = nib; v.en = en; v.ack = ack;
      tbl.push_back(v);
   endtask

   // One full frame of 4 slots, each: 1 guard cycle then 3 selected cycles.
   task automatic add_frame(input logic [15:0] sh, input logic [3:0] en_mask);
      for (int k = 0; k < 4; k++) begin
         logic [3:0] an_low;
         logic [3:0] nib;
         an_low    = 4'b1111;
         an_low[k] = 1'b0;
         nib       = sh[4*k +: 4];
         for (int c = 0; c < 4; c++) begin
            add_row(1'b1, 1'b0, 16'h0, (c == 0) ? 4'b1111 : an_low, nib, en_mask[k], 1'b0);
         end
      end
   endtask

   // Row numbers are 1-based.
   task automatic set_load(input int r, input logic [15:0] v);
      vec_t e;
      e = tbl[r-1];
      e.ld  = 1'b1;
      e.val = v;
      tbl[r-1] = e;
   endtask

   task automatic set_ack(input int r);
      vec_t e;
      e = tbl[r-1];
      e.ack = 1'b1;
      tbl[r-1] = e;
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] an, input logic [3:0] nib,
                                input logic en, input logic ack);
      check({tag, " anode"},      bus.anode,                an);
      check({tag, " digit_nib"},  bus.digit_nib,            nib);
      check({tag, " dec_enable"}, {3'b000, bus.dec_enable}, {3'b000, en});
      check({tag, " upd_ack"},    {3'b000, bus.upd_ack},    {3'b000, ack});
   endtask

   initial begin
      bit found;

      bus.display_on = 1'b0;
      bus.load       = 1'b0;
      bus.value      = 16'h0;

      // ---------------- stimulus table ----------------
      add_row(1'b1, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0);        // 1: enter SCAN
      add_frame(16'h0000, 4'b0001);                              // 2-17: zero shadow
      add_row(1'b0, 1'b0, 16'h0, 4'hF, 4'h0, 1'b1, 1'b0);        // 18: drop, outputs lag
      add_row(1'b0, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0);        // 19: dark
      add_row(1'b0, 1'b1, 16'h1234, 4'hF, 4'h0, 1'b0, 1'b0);     // 20: load while OFF
      add_row(1'b0, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b1);        // 21: ack
      add_row(1'b0, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0);        // 22
      add_row(1'b1, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0);        // 23: enter SCAN
      add_frame(16'h1234, 4'b1111);                              // 24-39
      add_row(1'b1, 1'b0, 16'h0, 4'hF, 4'h4, 1'b1, 1'b0);        // 40: slot0 guard
      add_row(1'b1, 1'b0, 16'h0, 4'hE, 4'h4, 1'b1, 1'b0);        // 41
      add_row(1'b0, 1'b0, 16'h0, 4'hE, 4'h4, 1'b1, 1'b0);        // 42: drop mid-slot
      add_row(1'b0, 1'b1, 16'h1111, 4'hF, 4'h0, 1'b0, 1'b0);     // 43: load while OFF
      add_row(1'b0, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b1);        // 44: ack
      add_row(1'b1, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0);        // 45: enter SCAN
      add_frame(16'h1111, 4'b1111);                              // 46-61
      add_frame(16'h3333, 4'b1111);                              // 62-77
      add_frame(16'h5555, 4'b1111);                              // 78-93
      add_frame(16'h00A0, 4'b0011);                              // 94-109
      set_load(51, 16'h2222);   // idx 1
      set_load(56, 16'h3333);   // idx 2, overwrites staging
      set_ack(61);              // frame_wrap transfer
      set_load(68, 16'h4444);   // pending in frame B
      set_load(77, 16'h5555);   // coincident with frame_wrap: bypass
      set_ack(77);
      set_load(85, 16'h00A0);
      set_ack(93);

      // ---------------- reset state ----------------
      #1 reset = 1'b1;
      #2;
      check_outputs("reset", 4'hF, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // ---------------- table loop ----------------
      for (int i = 0; i < tbl.size(); i++) begin
         bus.display_on = tbl[i].don;
         bus.load       = tbl[i].ld;
         bus.value      = tbl[i].val;
         @(posedge clk);
         #1;
         check_outputs($sformatf("row%0d", i + 1), tbl[i].an, tbl[i].nib, tbl[i].en, tbl[i].ack);
         $display("row %0d don=%b ld=%b val=%h anode=%b nib=%h en=%b ack=%b",
                  i + 1, tbl[i].don, tbl[i].ld, tbl[i].val,
                  bus.anode, bus.digit_nib, bus.dec_enable, bus.upd_ack);
      end
      bus.load = 1'b0;

      // ---------------- wait for blanked digit 2 with anode low ----------------
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(posedge clk);
         #1;
         if (bus.anode == 4'b1011) found = 1'b1;
      end
      check("slot2_reached", {3'b000, found}, 4'h1);
      check("slot2 digit_nib", bus.digit_nib, 4'h0);
      check("slot2 dec_enable", {3'b000, bus.dec_enable}, 4'h0);
      $display("slot2 wait anode=%b nib=%h en=%b", bus.anode, bus.digit_nib, bus.dec_enable);

      // ---------------- asynchronous reset mid-slot ----------------
      #2 reset = 1'b1;
      #1;
      check_outputs("async_reset", 4'hF, 4'h0, 1'b0, 1'b0);
      $display("async reset anode=%b nib=%h en=%b ack=%b",
               bus.anode, bus.digit_nib, bus.dec_enable, bus.upd_ack);
      @(negedge clk);
      reset = 1'b0;

      // Restart after reset: shadow cleared, scan begins at digit 0.
      bus.display_on = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("restart0", 4'hF, 4'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("restart1", 4'hF, 4'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("restart2", 4'hE, 4'h0, 1'b1, 1'b0);
      $display("restart anode=%b nib=%h en=%b", bus.anode, bus.digit_nib, bus.dec_enable);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller for a bank of common-anode seven-segment digits. Holds a multi-digit hex value in a tear-free shadow register and presents one nibble per slot to the existing seven-segment decoder. It drives the decoder's 4-bit input and enable together with the active-low digit anodes. Adds leading-zero blanking and anode dead-time against ghosting.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
GUARD, 2, cycles at the start of each slot with all anodes off (0 <= GUARD < REFRESH_DIV)
BLANK_LEADING, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
value  input  4*NUM_DIGITS  hex value; nibble k = digit k, digit 0 = least significant
load  input  1  single-cycle request to display value
display_on  input  1  0 = display dark and scan halted
upd_ack  output  1  one-cycle pulse when a staged value reaches the shadow register
digit_nib  output  4  nibble sent to the decoder input
dec_enable  output  1  decoder enable; 0 blanks the segments
anode  output  NUM_DIGITS  active-low digit selects; at most one bit is low

Behaviour:
- Reset (async, active-high): state OFF, prescaler=0, idx=0, staging=0, shadow=0, pending=0. Outputs: anode=all ones, dec_enable=0, digit_nib=0, upd_ack=0.
- States: OFF and SCAN. OFF->SCAN when display_on=1, starting at idx=0, prescaler=0. SCAN->OFF in the first cycle display_on=0; counters clear and outputs return to reset values one cycle later.
- Prescaler: counts 0..REFRESH_DIV-1 in SCAN. tick=1 when count==REFRESH_DIV-1. On tick, count->0 and idx increments. idx wraps NUM_DIGITS-1->0.
- frame_wrap = tick AND idx==NUM_DIGITS-1.
- Slot outputs for idx=k: anode all ones while count<GUARD, anode[k]=0 otherwise. digit_nib=shadow[4k+3:4k]. dec_enable=0 if blanked, else 1.
- Blanking: digit k is blanked when BLANK_LEADING=1, k>0, and shadow nibbles k..NUM_DIGITS-1 are all zero.
- All outputs are registered and lag the internal (state, idx, count) by exactly one clock.
- Load handshake:
  - load=1: staging<=value, pending<=1.
  - In SCAN on frame_wrap with pending=1: shadow<=staging, pending<=0.
  - In OFF, any pending=1 transfers on the next cycle.
  - Each transfer produces a single upd_ack pulse on the following cycle.
  - Repeated loads before a transfer overwrite staging and yield only one ack.
- Simultaneous load and transfer cycle: shadow<=value (bypass, newest wins), pending<=0, one ack.
- The shadow register only changes at a frame boundary or in OFF, so a frame never shows mixed old/new digits.
- display_on dropping mid-slot: the slot is abandoned; the next SCAN entry restarts at digit 0.

Decomposition:
- Shared package seven_seg_pkg: ANODE_OFF (all-ones) constant; scan state enum {OFF, SCAN}; default NUM_DIGITS/REFRESH_DIV/GUARD constants.
- One sub-module: seven_seg_prescaler. Counter 0..DIV-1 with enable, synchronous clear, and tick output; instantiated once.

Test Plan:
(all with NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, BLANK_LEADING=1)
1. Reset then display_on=1 with shadow=0 -> digit 0 slot: anode=1111 for 1 cycle, then 1110 for 3 cycles, digit_nib=0, dec_enable=1. Digits 1-3 have dec_enable=0.
2. load with value=16'h1234 while display_on=0 -> upd_ack 2 cycles later. Then display_on=1 -> slots show nib 4,3,2,1 with anode 1110,1101,1011,0111, each slot repeating every 16 cycles.
3. Shadow=16'h00A0, SCAN -> digits 0,1 dec_enable=1 (nib 0, A); digits 2,3 dec_enable=0 with their anodes still low after the guard.
4. Shadow=16'h1111, load 16'h2222 at idx=1, then load 16'h3333 at idx=2 -> exactly one upd_ack after frame_wrap. The next frame shows all 3s, and no frame mixes 1s with 3s.
5. load coincident with the frame_wrap cycle carrying value=16'h5555 while 16'h4444 is pending -> next frame shows all 5s, one upd_ack.
6. reset asserted mid-slot with anode=1011 -> anode=1111, dec_enable=0, upd_ack=0 immediately (asynchronous, not waiting for clk).
